// File: rtl/n4_b2_mul_seq_if.sv
// Start/busy/done handshake and operand/product bus of the sequential 4x4 multiplier.
// The master issues requests and operands; the slave returns the product and status.
interface n4_b2_mul_seq_if;
   logic       start;
   logic [3:0] x3_x0;
   logic [3:0] y3_y0;
   logic [7:0] p7_p0;
   logic       busy;
   logic       done;

   modport master (
      output start,
      output x3_x0,
      output y3_y0,
      input  p7_p0,
      input  busy,
      input  done
   );

   modport slave (
      input  start,
      input  x3_x0,
      input  y3_y0,
      output p7_p0,
      output busy,
      output done
   );
endinterface

// File: rtl/n4_b2_mul_seq.sv
// Shift-and-add unsigned 4x4 multiplier. One 4-digit ripple adder is reused once per
// iteration, giving one product every six cycles.

module n4_b2_adder (
   input  logic [3:0] a3_a0,
   input  logic [3:0] b3_b0,
   input  logic       cin,
   output logic [3:0] s3_s0,
   output logic       cout
);
   logic [4:0] carry;

   assign carry[0] = cin;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi = gi + 1) begin : g_digit
         assign s3_s0[gi]   = a3_a0[gi] ^ b3_b0[gi] ^ carry[gi];
         assign carry[gi+1] = (a3_a0[gi] & b3_b0[gi]) |
                              (carry[gi] & (a3_a0[gi] ^ b3_b0[gi]));
      end
   endgenerate

   assign cout = carry[4];
endmodule

module n4_b2_mul_seq (
   input  logic           clock,
   input  logic           reset,
   n4_b2_mul_seq_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t     state_reg;
   state_t     state_next;

   logic [3:0] a_reg;
   logic [3:0] q_reg;
   logic [3:0] m_reg;
   logic [1:0] cnt_reg;
   logic [7:0] p_reg;

   logic [3:0] a_next;
   logic [3:0] q_next;
   logic [3:0] m_next;
   logic [1:0] cnt_next;
   logic [7:0] p_next;

   logic       load;
   logic       step;
   logic       last;

   logic [3:0] addend;
   logic [3:0] sum;
   logic       carry;

   // Partial product for this iteration: add M only when the multiplier LSB is set.
   assign addend = q_reg[0] ? m_reg : 4'b0000;

   n4_b2_adder u_adder (
      .a3_a0 (a_reg),
      .b3_b0 (addend),
      .cin   (1'b0),
      .s3_s0 (sum),
      .cout  (carry)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      load       = 1'b0;
      step       = 1'b0;
      last       = 1'b0;
      case (state_reg)
         IDLE: begin
            if (bus.start) begin
               load       = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            step = 1'b1;
            if (cnt_reg == 2'd3) begin
               last       = 1'b1;
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // The adder carry shifts into A[3] and S[0] shifts into Q[3], so the
   // concatenation {A,Q} moves right one place per iteration.
   always_comb begin
      a_next   = a_reg;
      q_next   = q_reg;
      m_next   = m_reg;
      cnt_next = cnt_reg;
      p_next   = p_reg;
      if (load) begin
         a_next   = 4'b0000;
         q_next   = bus.y3_y0;
         m_next   = bus.x3_x0;
         cnt_next = 2'd0;
      end else if (step) begin
         a_next   = {carry, sum[3:1]};
         q_next   = {sum[0], q_reg[3:1]};
         cnt_next = cnt_reg + 2'd1;
         if (last) begin
            p_next = {carry, sum[3:1], sum[0], q_reg[3:1]};
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         a_reg   <= 4'b0000;
         q_reg   <= 4'b0000;
         m_reg   <= 4'b0000;
         cnt_reg <= 2'd0;
         p_reg   <= 8'h00;
      end else begin
         a_reg   <= a_next;
         q_reg   <= q_next;
         m_reg   <= m_next;
         cnt_reg <= cnt_next;
         p_reg   <= p_next;
      end
   end

   assign bus.p7_p0 = p_reg;
   assign bus.busy  = (state_reg != IDLE);
   assign bus.done  = (state_reg == DONE);
endmodule

// File: tb/tb_n4_b2_mul_seq.sv
// Directed bench for the sequential multiplier: expected products go into a queue at
// issue time and a monitor pops and compares them on every done pulse.
module tb_n4_b2_mul_seq;
   logic clock;
   logic reset;

   n4_b2_mul_seq_if bif ();

   n4_b2_mul_seq dut (
      .clock (clock),
      .reset (reset),
      .bus   (bif)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int        checks   = 0;
   int        failures = 0;
   int        cycle    = 0;
   logic [7:0] exp_q[$];

   always @(posedge clock) cycle <= cycle + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         failures = failures + 1;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end else begin
         $display("ok   %s: %0h (t=%0t)", name, act, $time);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clock) begin
      if (bif.done === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks   = checks + 1;
            failures = failures + 1;
            $display("FAIL unexpected_done: got p=%0h expected no done", bif.p7_p0);
         end else begin
            chk("product", {24'd0, bif.p7_p0}, {24'd0, exp_q.pop_front()});
         end
      end
   end

   // Waits (at negedges) until done is seen; returns negedges counted including the first.
   task automatic wait_done(input int start_n, output int n, output int at_cycle);
      n = start_n;
      while (bif.done !== 1'b1 && n < 20) begin
         @(negedge clock);
         n = n + 1;
      end
      at_cycle = cycle;
      if (bif.done !== 1'b1) begin
         checks   = checks + 1;
         failures = failures + 1;
         $display("FAIL done_timeout: got no done expected done within 20 cycles");
      end
   endtask

   task automatic do_op(input logic [3:0] x, input logic [3:0] y, input logic [7:0] e);
      int n;
      int c;
      @(negedge clock);
      bif.start = 1'b1;
      bif.x3_x0 = x;
      bif.y3_y0 = y;
      exp_q.push_back(e);
      @(negedge clock);
      bif.start = 1'b0;
      bif.x3_x0 = ~x;
      bif.y3_y0 = ~y;
      chk("busy_rise", {31'd0, bif.busy}, 32'd1);
      wait_done(1, n, c);
      chk("busy_cycles", n, 32'd5);
      @(negedge clock);
      chk("busy_fall", {31'd0, bif.busy}, 32'd0);
      chk("done_fall", {31'd0, bif.done}, 32'd0);
   endtask

   initial begin
      int n;
      int c1;
      int c2;
      reset     = 1'b1;
      bif.start = 1'b0;
      bif.x3_x0 = 4'h0;
      bif.y3_y0 = 4'h0;
      @(negedge clock);
      @(negedge clock);
      chk("reset_busy", {31'd0, bif.busy}, 32'd0);
      chk("reset_done", {31'd0, bif.done}, 32'd0);
      chk("reset_p", {24'd0, bif.p7_p0}, 32'h00);
      reset = 1'b0;

      do_op(4'd5, 4'd3, 8'h0F);
      do_op(4'hF, 4'hF, 8'hE1);
      do_op(4'd0, 4'd9, 8'h00);
      do_op(4'd9, 4'd0, 8'h00);
      do_op(4'd1, 4'd1, 8'h01);

      // Request during RUN is ignored until the block returns to IDLE.
      @(negedge clock);
      bif.start = 1'b1;
      bif.x3_x0 = 4'd6;
      bif.y3_y0 = 4'd7;
      exp_q.push_back(8'h2A);
      @(negedge clock);
      bif.x3_x0 = 4'd2;
      bif.y3_y0 = 4'd2;
      exp_q.push_back(8'h04);
      wait_done(1, n, c1);
      chk("ign_busy_cycles", n, 32'd5);
      @(negedge clock);
      chk("ign_gap_idle", {31'd0, bif.busy}, 32'd0);
      chk("ign_gap_p", {24'd0, bif.p7_p0}, 32'h2A);
      @(negedge clock);
      bif.start = 1'b0;
      chk("ign_second_busy", {31'd0, bif.busy}, 32'd1);
      chk("ign_hold_p", {24'd0, bif.p7_p0}, 32'h2A);
      wait_done(1, n, c2);
      chk("ign_second_cycles", n, 32'd5);
      @(negedge clock);

      // Back-to-back with start held high.
      @(negedge clock);
      bif.start = 1'b1;
      bif.x3_x0 = 4'd3;
      bif.y3_y0 = 4'd4;
      exp_q.push_back(8'h0C);
      @(negedge clock);
      bif.x3_x0 = 4'd12;
      bif.y3_y0 = 4'd11;
      exp_q.push_back(8'h84);
      wait_done(1, n, c1);
      @(negedge clock);
      wait_done(0, n, c2);
      bif.start = 1'b0;
      chk("b2b_spacing", c2 - c1, 32'd6);
      @(negedge clock);
      @(negedge clock);
      chk("b2b_no_third", {31'd0, bif.busy}, 32'd0);

      // Asynchronous reset between E2 and E3 aborts without a done pulse.
      @(negedge clock);
      bif.start = 1'b1;
      bif.x3_x0 = 4'd7;
      bif.y3_y0 = 4'd7;
      @(negedge clock);
      bif.start = 1'b0;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      #1;
      chk("abort_busy", {31'd0, bif.busy}, 32'd0);
      chk("abort_done", {31'd0, bif.done}, 32'd0);
      chk("abort_p", {24'd0, bif.p7_p0}, 32'h00);
      @(negedge clock);
      reset = 1'b0;
      do_op(4'd7, 4'd7, 8'h31);

      repeat (3) @(negedge clock);
      chk("queue_empty", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
